timer_set_controller: RTL

Front-end sequencer for the timer minute-setting datapath. Debounces the add/sub buttons and applies single steps plus hold-to-repeat steps to a two-digit BCD minute value (units, tens). On commit, it presents the 16-bit preset word to the counter flip-flop loader over a valid/ready handshake. Sits between the raw button inputs and the counter preset/set load logic.

---
 rtl/timer_set_controller.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/timer_set_controller.sv
// Minute-setting front end: debounced add/sub buttons step a two-digit BCD value
// (single step plus hold-to-repeat); a commit press offers the preset word to the loader.

module tsc_debounce #(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level
);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CNT_THR = CW'(DEBOUNCE_CYC - 1);

   logic          s1_q, s2_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!s2_q)                cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
   end

   // level asserts on the cycle the count reaches the threshold, not one later
   assign level = s2_q && (cnt_q >= CNT_THR);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= din;
         s2_q  <= s1_q;
         cnt_q <= cnt_d;
      end
   end
endmodule

module timer_set_controller #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int REPEAT_DLY   = 8,
   parameter int REPEAT_PER   = 4,
   parameter bit SAT          = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        add,
   input  logic        sub,
   input  logic        commit,
   input  logic        load_ready,
   output logic [7:0]  set_min,
   output logic [15:0] out_final,
   output logic        load_valid,
   output logic        busy,
   output logic        wrap_evt
);
   localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DLY - 1);
   localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PER - 1);

   typedef enum logic [1:0] {IDLE, HOLD_FIRST, HOLD_REPEAT, LOAD} state_e;

   state_e        state_q, state_d;
   logic [7:0]    set_min_q, set_min_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          dir_q, dir_d;
   logic          wrap_q, wrap_d;
   logic          com_s1_q, com_s2_q, com_s3_q;
   logic [1:0]    btn_raw, btn_db;
   logic          one_btn, both_btn, held, commit_rise, step_en, step_up;

   // index 0 = add, index 1 = sub
   assign btn_raw = {sub, add};
   for (genvar b = 0; b < 2; b++) begin : g_btn
      tsc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
         .clk(clk), .rst_n(rst_n), .din(btn_raw[b]), .level(btn_db[b])
      );
   end

   assign one_btn     = btn_db[0] ^ btn_db[1];
   assign both_btn    = &btn_db;
   assign held        = dir_q ? btn_db[0] : btn_db[1];
   assign commit_rise = com_s2_q & ~com_s3_q;

   // {wrap, next value}; dir up = 1
   function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic up);
      logic [3:0] t, u;
      t = v[7:4];
      u = v[3:0];
      if (up) begin
         if (v == 8'h99)    bcd_step = SAT ? {1'b0, v} : {1'b1, 8'h00};
         else if (u == 4'd9) bcd_step = {1'b0, t + 4'd1, 4'd0};
         else                bcd_step = {1'b0, t, u + 4'd1};
      end else begin
         if (v == 8'h00)    bcd_step = SAT ? {1'b0, v} : {1'b1, 8'h99};
         else if (u == 4'd0) bcd_step = {1'b0, t - 4'd1, 4'd9};
         else                bcd_step = {1'b0, t, u - 4'd1};
      end
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         set_min_q <= 8'h00;
         timer_q   <= '0;
         dir_q     <= 1'b0;
         wrap_q    <= 1'b0;
         com_s1_q  <= 1'b0;
         com_s2_q  <= 1'b0;
         com_s3_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         set_min_q <= set_min_d;
         timer_q   <= timer_d;
         dir_q     <= dir_d;
         wrap_q    <= wrap_d;
         com_s1_q  <= commit;
         com_s2_q  <= com_s1_q;
         com_s3_q  <= com_s2_q;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      dir_d   = dir_q;
      step_en = 1'b0;
      step_up = dir_q;
      unique case (state_q)
         IDLE: begin
            if (one_btn) begin
               step_en = 1'b1;
               step_up = btn_db[0];
               dir_d   = btn_db[0];
               timer_d = '0;
               state_d = HOLD_FIRST;
            end else if (commit_rise) begin
               state_d = LOAD;
            end
         end
         HOLD_FIRST: begin
            if (!held || both_btn) state_d = IDLE;
            else if (timer_q == DLY_LAST) begin
               step_en = 1'b1;
               timer_d = '0;
               state_d = HOLD_REPEAT;
            end else timer_d = timer_q + 1'b1;
         end
         HOLD_REPEAT: begin
            if (!held || both_btn) state_d = IDLE;
            else if (timer_q == PER_LAST) begin
               step_en = 1'b1;
               timer_d = '0;
            end else timer_d = timer_q + 1'b1;
         end
         LOAD: if (load_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      {wrap_d, set_min_d} = step_en ? bcd_step(set_min_q, step_up) : {1'b0, set_min_q};
   end

   always_comb begin
      set_min    = set_min_q;
      out_final  = {set_min_q, 8'h00};
      load_valid = (state_q == LOAD);
      busy       = (state_q != IDLE);
      wrap_evt   = wrap_q;
   end
endmodule
